ps2_keyboard: RTL and testbench
===============================

Name: ps2_keyboard

Overview:
PS/2 keyboard receiver and scancode decoder (set 2). It produces the single-cycle `keyboard_symbol` pulse stream consumed by `logic_`: ASCII for printable keys, 1/2/3 for left arrow, right arrow and backspace, 0 when idle. It sits between the board PS/2 pins and `logic_` in `top`. It is the producer end of the `keyboard_symbol` interface.

Parameters:
- SYMBOL_WIDTH, 7, width of `keyboard_symbol`.
- TIMEOUT_CYCLES, 25175, clk cycles without a `ps2_clk` falling edge before a partial frame is abandoned (~1 ms at 25.175 MHz).

Ports:
- clk  in  1  system clock, 25.175 MHz.
- rst_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  PS/2 clock pin, asynchronous.
- ps2_data  in  1  PS/2 data pin, asynchronous.
- keyboard_symbol  out  SYMBOL_WIDTH  symbol pulse, valid for one cycle; 0 = no symbol.
- frame_error  out  1  one-cycle pulse on a parity, stop or timeout error.

Behaviour:
- Reset is asynchronous, active-low; it is the only asynchronous element. While rst_n=0: `keyboard_symbol`=0, `frame_error`=0, receiver in IDLE, shift/break/extended flags cleared, synchronizers loaded with 1.
- Synchronization: 2-FF synchronizer on each pin, plus a registered previous value of the synced clock. A falling edge is prev=1, cur=0. Data is sampled on that edge.
- Receiver FSM:
  - IDLE: on an edge with data=0 (start bit), go to DATA with bit count 0. An edge with data=1 is ignored.
  - DATA: shift in 8 bits, LSB first; after the 8th bit go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: on the edge, the frame is good if the stop bit is 1 and the 9-bit ones-count (8 data bits + parity) is odd. Good: byte_valid pulses for 1 cycle. Bad: `frame_error` pulses and the decoder flags are cleared. Either way, return to IDLE.
- Timeout: a counter clears on every falling edge and counts while not in IDLE. On reaching TIMEOUT_CYCLES-1 the FSM goes to IDLE, `frame_error` pulses, and decoder flags are cleared. No symbol is emitted.
- Decoder, per valid byte:
  - E0: set `ext`.
  - F0: set `brk`.
  - Any other byte: if `brk`, it is a release (12 or 59 clears `shift`; anything else no output). If not `brk`, it is a press (12 or 59 sets `shift`; otherwise look up the table and emit if mapped). Then clear `ext` and `brk`.
  - Unmapped codes emit nothing.
  - Typematic repeats of a press emit a pulse each time.
- Table, non-extended, unshifted:
  - Digits: 45→'0', 16→'1', 1E→'2', 26→'3', 25→'4', 2E→'5', 36→'6', 3D→'7', 3E→'8', 46→'9'.
  - Letters a–z (lowercase): 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Punctuation: 4E '-', 55 '=', 49 '.', 4A '/', 29 ' '.
  - Backspace: 66→3.
- Table, shifted:
  - 36 '^', 3E '*', 46 '(', 45 ')', 55 '+'.
  - Letters stay lowercase.
  - Other shifted digits and punctuation emit nothing.
- Table, extended (`ext`=1): 6B→1, 74→2. All other extended codes emit nothing.
- Latency: `keyboard_symbol` is registered and asserts exactly 2 clk cycles after the cycle in which the synced STOP falling edge is detected. It lasts exactly 1 cycle, then returns to 0.
- Back-to-back frames: no minimum gap beyond PS/2 timing. The decoder consumes one byte per byte_valid and never stalls.
- Reset mid-frame: the partial frame is discarded and no pulse is emitted.

Optional Feature:
- Macro: PS2_KEYBOARD_KEYPAD_EN.
- Defined: numeric keypad keys are mapped regardless of NumLock or `shift`:
  - Digits: 70 '0', 69 '1', 72 '2', 7A '3', 6B '4', 73 '5', 74 '6', 6C '7', 75 '8', 7D '9'.
  - Operators: 71 '.', 79 '+', 7B '-', 7C '*', E0 4A '/'.
  - Non-extended 6B/74 here are keypad 4/6. The arrow keys are E0 6B / E0 74 and stay mapped to 1/2.
- Undefined: all of these codes emit nothing. E0 4A emits nothing.

Test Plan:
- Send frame 16 (data 0x16, parity 0, stop 1) → `keyboard_symbol`=0x31 for exactly 1 cycle, 2 cycles after the synced stop edge; `frame_error` stays 0.
- Send E0 6B, then E0 F0 6B → one pulse of 1, no pulse on release. Send 66 → one pulse of 3.
- Send 12, 3E, F0 3E, F0 12, 3E → pulses '*' (0x2A) then '8' (0x38), nothing else.
- Send 0x1C with the parity bit flipped → `frame_error` pulses once and there is no symbol. Send 0x1C correctly → 'a' (0x61).
- Send start bit plus 4 data bits, then idle for TIMEOUT_CYCLES → `frame_error` pulses. Send a full frame 45 → '0'. Pulse rst_n low mid-frame → outputs 0 and the next frame decodes normally.
- With PS2_KEYBOARD_KEYPAD_EN, send 79 → '+'. Without it, send 79 → no pulse. In both builds, E0 74 → 2.

Source files
------------

// File: rtl/ps2_keyboard_if.sv
// PS/2 keyboard signal bundle: board pins in, keyboard_symbol/frame_error pulses out.
// master = receiver/decoder side, slave = pin driver plus symbol consumer side.
interface ps2_keyboard_if #(
  parameter int SYMBOL_WIDTH = 7
);
  logic                    ps2_clk;
  logic                    ps2_data;
  logic [SYMBOL_WIDTH-1:0] keyboard_symbol;
  logic                    frame_error;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output keyboard_symbol,
    output frame_error
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  keyboard_symbol,
    input  frame_error
  );
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 set-2 receiver and scancode decoder emitting one-cycle keyboard_symbol pulses.
// Optional macro PS2_KEYBOARD_KEYPAD_EN maps the numeric keypad keys.
module ps2_keyboard #(
  parameter int SYMBOL_WIDTH   = 7,
  parameter int TIMEOUT_CYCLES = 25175
) (
  input  logic           clk,
  input  logic           rst_n,
  ps2_keyboard_if.master kbd
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [1:0]              clk_sync, data_sync;
  logic                    clk_prev;
  logic                    fall, bit_in, timeout;
  state_t                  state, state_d;
  logic [2:0]              bit_cnt, bit_cnt_d;
  logic [7:0]              shreg, shreg_d;
  logic                    par, par_d;
  logic                    byte_valid, byte_valid_d;
  logic                    frame_err, frame_err_d;
  logic [TW-1:0]           to_cnt;
  logic                    ext, brk, shift;
  logic [SYMBOL_WIDTH-1:0] symbol;

  // Synchronizers reset to 1 (idle bus level) so reset release never looks like an edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], kbd.ps2_clk};
      data_sync <= {data_sync[0], kbd.ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall    = clk_prev & ~clk_sync[1];
  assign bit_in  = data_sync[1];
  assign timeout = (state != S_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      to_cnt <= '0;
    else if (fall || state == S_IDLE) to_cnt <= '0;
    else                             to_cnt <= to_cnt + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      bit_cnt    <= bit_cnt_d;
      shreg      <= shreg_d;
      par        <= par_d;
      byte_valid <= byte_valid_d;
      frame_err  <= frame_err_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state;
    bit_cnt_d    = bit_cnt;
    shreg_d      = shreg;
    par_d        = par;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (timeout) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
    end else if (fall) begin
      case (state)
        S_IDLE: begin
          if (!bit_in) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shreg_d   = {bit_in, shreg[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = bit_in;
          state_d = S_STOP;
        end
        S_STOP: begin
          // Odd parity over data plus parity bit, and a high stop bit.
          if (bit_in && (^{shreg, par})) byte_valid_d = 1'b1;
          else                           frame_err_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  function automatic logic [6:0] lookup(input logic [7:0] code, input logic is_ext,
                                        input logic is_shift);
    lookup = 7'h00;
    if (is_ext) begin
      case (code)
        8'h6B: lookup = 7'd1;
        8'h74: lookup = 7'd2;
`ifdef PS2_KEYBOARD_KEYPAD_EN
        8'h4A: lookup = 7'h2F;
`endif
        default: lookup = 7'h00;
      endcase
    end else begin
      case (code)
        8'h1C: lookup = 7'h61;  8'h32: lookup = 7'h62;  8'h21: lookup = 7'h63;
        8'h23: lookup = 7'h64;  8'h24: lookup = 7'h65;  8'h2B: lookup = 7'h66;
        8'h34: lookup = 7'h67;  8'h33: lookup = 7'h68;  8'h43: lookup = 7'h69;
        8'h3B: lookup = 7'h6A;  8'h42: lookup = 7'h6B;  8'h4B: lookup = 7'h6C;
        8'h3A: lookup = 7'h6D;  8'h31: lookup = 7'h6E;  8'h44: lookup = 7'h6F;
        8'h4D: lookup = 7'h70;  8'h15: lookup = 7'h71;  8'h2D: lookup = 7'h72;
        8'h1B: lookup = 7'h73;  8'h2C: lookup = 7'h74;  8'h3C: lookup = 7'h75;
        8'h2A: lookup = 7'h76;  8'h1D: lookup = 7'h77;  8'h22: lookup = 7'h78;
        8'h35: lookup = 7'h79;  8'h1A: lookup = 7'h7A;
        8'h66: lookup = 7'd3;
`ifdef PS2_KEYBOARD_KEYPAD_EN
        8'h70: lookup = 7'h30;  8'h69: lookup = 7'h31;  8'h72: lookup = 7'h32;
        8'h7A: lookup = 7'h33;  8'h6B: lookup = 7'h34;  8'h73: lookup = 7'h35;
        8'h74: lookup = 7'h36;  8'h6C: lookup = 7'h37;  8'h75: lookup = 7'h38;
        8'h7D: lookup = 7'h39;  8'h71: lookup = 7'h2E;  8'h79: lookup = 7'h2B;
        8'h7B: lookup = 7'h2D;  8'h7C: lookup = 7'h2A;
`endif
        default: begin
          if (is_shift) begin
            case (code)
              8'h36: lookup = 7'h5E;  8'h3E: lookup = 7'h2A;  8'h46: lookup = 7'h28;
              8'h45: lookup = 7'h29;  8'h55: lookup = 7'h2B;
              default: lookup = 7'h00;
            endcase
          end else begin
            case (code)
              8'h45: lookup = 7'h30;  8'h16: lookup = 7'h31;  8'h1E: lookup = 7'h32;
              8'h26: lookup = 7'h33;  8'h25: lookup = 7'h34;  8'h2E: lookup = 7'h35;
              8'h36: lookup = 7'h36;  8'h3D: lookup = 7'h37;  8'h3E: lookup = 7'h38;
              8'h46: lookup = 7'h39;  8'h4E: lookup = 7'h2D;  8'h55: lookup = 7'h3D;
              8'h49: lookup = 7'h2E;  8'h4A: lookup = 7'h2F;  8'h29: lookup = 7'h20;
              default: lookup = 7'h00;
            endcase
          end
        end
      endcase
    end
  endfunction

  // Prefix bytes only set flags; the final byte of a sequence consumes and clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext    <= 1'b0;
      brk    <= 1'b0;
      shift  <= 1'b0;
      symbol <= '0;
    end else begin
      symbol <= '0;
      if (frame_err) begin
        ext   <= 1'b0;
        brk   <= 1'b0;
        shift <= 1'b0;
      end else if (byte_valid) begin
        if (shreg == 8'hE0) begin
          ext <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          if (shreg == 8'h12 || shreg == 8'h59) shift  <= !brk;
          else if (!brk)                        symbol <= SYMBOL_WIDTH'(lookup(shreg, ext, shift));
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

  assign kbd.keyboard_symbol = symbol;
  assign kbd.frame_error     = frame_err;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: latency, decode table, shift/extended/break, errors, reset.
module tb_ps2_keyboard;

  localparam int SW      = 7;
  localparam int TIMEOUT = 25175;
  localparam int HALF    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   err_cnt = 0;
  logic [SW-1:0] sym_q[$];

  ps2_keyboard_if #(.SYMBOL_WIDTH(SW)) kbd ();

  ps2_keyboard #(.SYMBOL_WIDTH(SW), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kbd   (kbd)
  );

  always #20 clk = ~clk;

  always @(negedge clk) begin
    if (kbd.keyboard_symbol !== '0) sym_q.push_back(kbd.keyboard_symbol);
    if (kbd.frame_error === 1'b1) err_cnt++;
  end

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    kbd.ps2_data = b;
    repeat (HALF) @(negedge clk);
    kbd.ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    kbd.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip_parity);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ flip_parity);
    ps2_bit(1'b1);
    repeat (HALF) @(negedge clk);
  endtask

  task automatic clear_mon();
    sym_q.delete();
    err_cnt = 0;
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (kbd.keyboard_symbol !== '0) begin
      n_bad++; $display("FAIL reset_symbol: got %h expected 00", kbd.keyboard_symbol);
    end
    n_cmp++;
    if (kbd.frame_error !== 1'b0) begin
      n_bad++; $display("FAIL reset_frame_error: got %b expected 0", kbd.frame_error);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    clear_mon();
  endtask

  task automatic test_latency();
    logic [7:0]    d;
    logic [SW-1:0] exp;
    d = 8'h16;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(1'b0);
    @(negedge clk);
    kbd.ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    kbd.ps2_clk = 1'b0;
    // Two synchronizer stages, edge detect, byte_valid, then the symbol register.
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      exp = (k == 4) ? SW'(7'h31) : '0;
      n_cmp++;
      if (kbd.keyboard_symbol !== exp) begin
        n_bad++; $display("FAIL latency_cycle%0d: got %h expected %h", k, kbd.keyboard_symbol, exp);
      end
    end
    repeat (HALF) @(negedge clk);
    kbd.ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    n_cmp++;
    if (sym_q.size() !== 1) begin
      n_bad++; $display("FAIL latency_pulse_count: got %0d expected 1", sym_q.size());
    end
    n_cmp++;
    if (err_cnt !== 0) begin
      n_bad++; $display("FAIL latency_frame_error: got %0d expected 0", err_cnt);
    end
    clear_mon();
  endtask

  task automatic test_arrows();
    send_frame(8'hE0, 1'b0); send_frame(8'h6B, 1'b0);
    send_frame(8'hE0, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h6B, 1'b0);
    send_frame(8'h66, 1'b0);
    n_cmp++;
    if (sym_q.size() !== 2) begin
      n_bad++; $display("FAIL arrows_count: got %0d expected 2", sym_q.size());
    end else begin
      n_cmp++;
      if (sym_q[0] !== 7'd1) begin
        n_bad++; $display("FAIL arrows_left: got %h expected 01", sym_q[0]);
      end
      n_cmp++;
      if (sym_q[1] !== 7'd3) begin
        n_bad++; $display("FAIL arrows_backspace: got %h expected 03", sym_q[1]);
      end
    end
    clear_mon();
  endtask

  task automatic test_shift();
    send_frame(8'h12, 1'b0); send_frame(8'h3E, 1'b0);
    send_frame(8'hF0, 1'b0); send_frame(8'h3E, 1'b0);
    send_frame(8'hF0, 1'b0); send_frame(8'h12, 1'b0);
    send_frame(8'h3E, 1'b0);
    n_cmp++;
    if (sym_q.size() !== 2) begin
      n_bad++; $display("FAIL shift_count: got %0d expected 2", sym_q.size());
    end else begin
      n_cmp++;
      if (sym_q[0] !== 7'h2A) begin
        n_bad++; $display("FAIL shift_star: got %h expected 2a", sym_q[0]);
      end
      n_cmp++;
      if (sym_q[1] !== 7'h38) begin
        n_bad++; $display("FAIL shift_eight: got %h expected 38", sym_q[1]);
      end
    end
    clear_mon();
  endtask

  task automatic test_table();
    logic [SW-1:0] exp[4];
    exp = '{7'h20, 7'h2F, 7'h7A, 7'h61};
    send_frame(8'h29, 1'b0); send_frame(8'h4A, 1'b0);
    send_frame(8'h5A, 1'b0); send_frame(8'h1A, 1'b0);
    send_frame(8'h12, 1'b0); send_frame(8'h16, 1'b0);
    send_frame(8'h1C, 1'b0); send_frame(8'hF0, 1'b0);
    send_frame(8'h12, 1'b0);
    n_cmp++;
    if (sym_q.size() !== 4) begin
      n_bad++; $display("FAIL table_count: got %0d expected 4", sym_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (sym_q[i] !== exp[i]) begin
          n_bad++; $display("FAIL table_sym%0d: got %h expected %h", i, sym_q[i], exp[i]);
        end
      end
    end
    clear_mon();
  endtask

  task automatic test_parity();
    send_frame(8'h1C, 1'b1);
    n_cmp++;
    if (err_cnt !== 1) begin
      n_bad++; $display("FAIL parity_error_count: got %0d expected 1", err_cnt);
    end
    n_cmp++;
    if (sym_q.size() !== 0) begin
      n_bad++; $display("FAIL parity_no_symbol: got %0d pulses expected 0", sym_q.size());
    end
    clear_mon();
    send_frame(8'h1C, 1'b0);
    n_cmp++;
    if (sym_q.size() !== 1 || sym_q[0] !== 7'h61) begin
      n_bad++; $display("FAIL parity_recover: got %0d pulses first %h expected 1 pulse 61",
                        sym_q.size(), sym_q.size() > 0 ? sym_q[0] : 7'h00);
    end
    clear_mon();
  endtask

  task automatic test_timeout();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TIMEOUT - 100) @(negedge clk);
    n_cmp++;
    if (err_cnt !== 0) begin
      n_bad++; $display("FAIL timeout_early: got %0d errors expected 0", err_cnt);
    end
    repeat (150) @(negedge clk);
    n_cmp++;
    if (err_cnt !== 1) begin
      n_bad++; $display("FAIL timeout_error: got %0d errors expected 1", err_cnt);
    end
    n_cmp++;
    if (sym_q.size() !== 0) begin
      n_bad++; $display("FAIL timeout_no_symbol: got %0d pulses expected 0", sym_q.size());
    end
    clear_mon();
    send_frame(8'h45, 1'b0);
    n_cmp++;
    if (sym_q.size() !== 1 || sym_q[0] !== 7'h30) begin
      n_bad++; $display("FAIL timeout_recover: got %0d pulses first %h expected 1 pulse 30",
                        sym_q.size(), sym_q.size() > 0 ? sym_q[0] : 7'h00);
    end
    clear_mon();
  endtask

  task automatic test_reset_mid_frame();
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (kbd.keyboard_symbol !== '0 || kbd.frame_error !== 1'b0) begin
      n_bad++; $display("FAIL midreset_outputs: got %h/%b expected 00/0",
                        kbd.keyboard_symbol, kbd.frame_error);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h2B, 1'b0);
    n_cmp++;
    if (sym_q.size() !== 1 || sym_q[0] !== 7'h66) begin
      n_bad++; $display("FAIL midreset_recover: got %0d pulses first %h expected 1 pulse 66",
                        sym_q.size(), sym_q.size() > 0 ? sym_q[0] : 7'h00);
    end
    n_cmp++;
    if (err_cnt !== 0) begin
      n_bad++; $display("FAIL midreset_frame_error: got %0d expected 0", err_cnt);
    end
    clear_mon();
  endtask

  task automatic test_keypad();
    int            n_exp;
    logic [SW-1:0] exp[2];
`ifdef PS2_KEYBOARD_KEYPAD_EN
    n_exp = 2;
    exp   = '{7'h2B, 7'd2};
`else
    n_exp = 1;
    exp   = '{7'd2, 7'h00};
`endif
    send_frame(8'h79, 1'b0);
    send_frame(8'hE0, 1'b0); send_frame(8'h74, 1'b0);
    n_cmp++;
    if (sym_q.size() !== n_exp) begin
      n_bad++; $display("FAIL keypad_count: got %0d expected %0d", sym_q.size(), n_exp);
    end else begin
      for (int i = 0; i < n_exp; i++) begin
        n_cmp++;
        if (sym_q[i] !== exp[i]) begin
          n_bad++; $display("FAIL keypad_sym%0d: got %h expected %h", i, sym_q[i], exp[i]);
        end
      end
    end
    clear_mon();
  endtask

  initial begin
    kbd.ps2_clk  = 1'b1;
    kbd.ps2_data = 1'b1;
    test_reset();
    test_latency();
    test_arrows();
    test_shift();
    test_table();
    test_parity();
    test_timeout();
    test_reset_mid_frame();
    test_keypad();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
